// File: rtl/jar_sram_pkg.sv
// Shared definitions for the nibble-serial 8x8 SRAM host and macro.
// Holds the host sequencer states and the io_in pin positions.
// The SRAM-side top reuses the pin constants so both ends agree on the bus.
package jar_sram_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR0,
    WR1,
    WR2,
    RD,
    RDS
  } state_t;

  // Bit positions on the SRAM io_in pin bus
  localparam int PIN_CLK    = 0;
  localparam int PIN_RST    = 1;
  localparam int PIN_WE     = 2;
  localparam int PIN_OE     = 3;
  localparam int PIN_NIB_LO = 4;

  // States that occupy a full SRAM clock period
  function automatic logic is_beat(input state_t s);
    return (s == INIT) || (s == WR0) || (s == WR1) || (s == WR2) || (s == RD);
  endfunction

endpackage

// File: rtl/jar_sram_clkgen.sv
// Beat timer: phase counter over one SRAM clock period of 2*HALF host cycles.
// mem_clk is registered, low for the first HALF cycles and high for the last HALF.
// beat_end strobes on the final cycle of a beat; the counter rests at 0 when disabled.
module jar_sram_clkgen #(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic beat_end,
  output logic mem_clk
);

  localparam int PERIOD = 2 * HALF;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_next;

  assign beat_end = en && (phase == PW'(PERIOD - 1));

  // Advance the phase inside a beat, wrap at the end, park at 0 otherwise
  always_comb begin
    phase_next = '0;
    if (en && !beat_end) begin
      phase_next = phase + 1'b1;
    end
  end

  // Phase and clock registers; mem_clk follows the phase it is about to enter
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      mem_clk <= 1'b0;
    end else begin
      phase   <= phase_next;
      mem_clk <= en && (phase_next >= PW'(HALF));
    end
  end

endmodule

// File: rtl/jar_sram_host.sv
// Host sequencer turning parallel read/write requests into nibble-serial SRAM beats.
// Write: 6*HALF+1 cycles until ready again; read: rsp_valid 2*HALF+2 cycles after accept.
// req_ready is high only in IDLE; requests offered while busy are ignored and must be held.
module jar_sram_host
  import jar_sram_pkg::*;
#(
  parameter int AW   = 3,
  parameter int DW   = 8,
  parameter int HALF = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            mem_clk,
  output logic            mem_rst,
  output logic            mem_we,
  output logic            mem_oe,
  output logic [DW/2-1:0] mem_nib,
  input  logic [DW-1:0]   mem_dout
);

  localparam int NW = DW / 2;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   wdata_n;
  logic            accept;
  logic            beat_end;
  logic            beat_en;
  logic            rst_nxt;
  logic            we_nxt;
  logic            oe_nxt;
  logic [NW-1:0]   nib_nxt;
  logic            ready_nxt;

  assign accept  = req_valid && req_ready;
  assign beat_en = is_beat(state);

  jar_sram_clkgen #(
    .HALF (HALF)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (beat_en),
    .beat_end (beat_end),
    .mem_clk  (mem_clk)
  );

  // Next state, request capture and the pin values for the state being entered
  always_comb begin
    state_next = state;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rst_nxt    = 1'b0;
    we_nxt     = 1'b0;
    oe_nxt     = 1'b0;
    nib_nxt    = '0;
    ready_nxt  = 1'b0;

    case (state)
      INIT: if (beat_end) state_next = IDLE;
      IDLE: begin
        if (accept) begin
          addr_n = req_addr;
          if (req_we) begin
            wdata_n    = req_wdata;
            state_next = WR0;
          end else begin
            state_next = RD;
          end
        end
      end
      WR0:     if (beat_end) state_next = WR1;
      WR1:     if (beat_end) state_next = WR2;
      WR2:     if (beat_end) state_next = IDLE;
      RD:      if (beat_end) state_next = RDS;
      RDS:     state_next = IDLE;
      default: state_next = INIT;
    endcase

    // Pins are decoded from the upcoming state so they change with mem_clk falling
    case (state_next)
      INIT: rst_nxt = 1'b1;
      IDLE: ready_nxt = 1'b1;
      WR0: begin
        we_nxt  = 1'b1;
        nib_nxt = wdata_n[NW-1:0];
      end
      WR1: begin
        we_nxt  = 1'b1;
        nib_nxt = wdata_n[DW-1:NW];
      end
      WR2: begin
        we_nxt  = 1'b1;
        nib_nxt = NW'(addr_n);
      end
      RD, RDS: begin
        oe_nxt  = 1'b1;
        nib_nxt = NW'(addr_n);
      end
      default: rst_nxt = 1'b1;
    endcase
  end

  // State register; reset from any state restarts with the SRAM reset beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Request latches, registered SRAM pins and the read response
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rst   <= 1'b1;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_nib   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      mem_rst   <= rst_nxt;
      mem_we    <= we_nxt;
      mem_oe    <= oe_nxt;
      mem_nib   <= nib_nxt;
      req_ready <= ready_nxt;
      rsp_valid <= (state == RDS);
      if (state == RDS) begin
        rsp_data <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_jar_sram_host.sv
// Bench for jar_sram_host: HALF=1 and HALF=3 instances, each driving a behavioural SRAM.
// Requests go through a queue-fed driver; results are compared against a reference memory.
// Outputs are sampled on the falling host clock edge.
module tb_jar_sram_host;
  import jar_sram_pkg::*;

  typedef struct packed {
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_valid3, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;

  logic       req_ready, rsp_valid, mem_clk, mem_rst, mem_we, mem_oe;
  logic [3:0] mem_nib;
  logic [7:0] rsp_data, mem_dout;
  logic       req_ready3, rsp_valid3, mem_clk3, mem_rst3, mem_we3, mem_oe3;
  logic [3:0] mem_nib3;
  logic [7:0] rsp_data3, mem_dout3;

  jar_sram_host #(.AW(3), .DW(8), .HALF(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_clk(mem_clk),
    .mem_rst(mem_rst), .mem_we(mem_we), .mem_oe(mem_oe), .mem_nib(mem_nib),
    .mem_dout(mem_dout));

  jar_sram_host #(.AW(3), .DW(8), .HALF(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .mem_clk(mem_clk3),
    .mem_rst(mem_rst3), .mem_we(mem_we3), .mem_oe(mem_oe3), .mem_nib(mem_nib3),
    .mem_dout(mem_dout3));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ref_mem [8];
  op_t        opq [$];
  int         acc_q [$];
  int         rdy_q [$];
  int         rsp_cyc [$];
  logic [7:0] rsp_dat [$];
  logic [6:0] ev_q [$];
  logic [7:0] trace [int];

  // SRAM pin bus as the macro sees it
  logic [7:0] io_in;
  always_comb begin
    io_in = '0;
    io_in[PIN_CLK] = mem_clk;
    io_in[PIN_RST] = mem_rst;
    io_in[PIN_WE]  = mem_we;
    io_in[PIN_OE]  = mem_oe;
    io_in[PIN_NIB_LO +: 4] = mem_nib;
  end

  function automatic logic [6:0] ev(input logic r, input logic w, input logic o, input logic [3:0] n);
    logic [7:0] b;
    b = '0;
    b[PIN_RST] = r;
    b[PIN_WE]  = w;
    b[PIN_OE]  = o;
    b[PIN_NIB_LO +: 4] = n;
    return b[7:1];
  endfunction

  // Behavioural nibble-serial SRAM for the HALF=1 instance
  logic [7:0] smem [8];
  logic [2:0] sra;
  initial begin : sram1
    int cnt;
    logic [3:0] lo, hi;
    cnt = 0; lo = '0; hi = '0; sra = '0;
    for (int i = 0; i < 8; i++) smem[i] = 8'(i * 29 + 19);
    forever begin
      @(posedge mem_clk);
      ev_q.push_back(io_in[7:1]);
      if (io_in[PIN_RST]) cnt = 0;
      else if (io_in[PIN_WE]) begin
        if (cnt == 0) lo = io_in[PIN_NIB_LO +: 4];
        else if (cnt == 1) hi = io_in[PIN_NIB_LO +: 4];
        else smem[io_in[PIN_NIB_LO +: 3]] = {hi, lo};
        cnt = (cnt == 2) ? 0 : cnt + 1;
      end else if (io_in[PIN_OE]) sra = io_in[PIN_NIB_LO +: 3];
    end
  end
  assign mem_dout = smem[sra];

  // Same SRAM behaviour for the HALF=3 instance
  logic [7:0] smem3 [8];
  logic [2:0] sra3;
  initial begin : sram3
    int cnt;
    logic [3:0] lo, hi;
    cnt = 0; lo = '0; hi = '0; sra3 = '0;
    for (int i = 0; i < 8; i++) smem3[i] = 8'(i * 29 + 19);
    forever begin
      @(posedge mem_clk3);
      if (mem_rst3) cnt = 0;
      else if (mem_we3) begin
        if (cnt == 0) lo = mem_nib3;
        else if (cnt == 1) hi = mem_nib3;
        else smem3[mem_nib3[2:0]] = {hi, lo};
        cnt = (cnt == 2) ? 0 : cnt + 1;
      end else if (mem_oe3) sra3 = mem_nib3[2:0];
    end
  end
  assign mem_dout3 = smem3[sra3];

  // Falling-edge monitor for the HALF=1 instance
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    trace[cyc] = {mem_clk, mem_rst, mem_we, mem_oe, mem_nib};
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_data);
    end
    if (req_ready && !rdy_prev) rdy_q.push_back(cyc);
    rdy_prev = req_ready;
  end

  // Request driver: presents queued ops, holding req_valid across consecutive ops
  initial begin : driver
    bit sent;
    sent = 0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      if (sent) begin
        sent = 0;
        void'(opq.pop_front());
        req_valid = 0;
        req_we    = 1'($urandom);
        req_addr  = 3'($urandom);
        req_wdata = 8'($urandom);
      end
      if (!req_valid && opq.size() > 0) begin
        req_valid = 1;
        req_we    = opq[0].we;
        req_addr  = opq[0].a;
        req_wdata = opq[0].d;
      end
      if (req_valid && req_ready && !rst) begin
        sent = 1;
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic clr();
    acc_q.delete(); rdy_q.delete(); rsp_cyc.delete(); rsp_dat.delete(); ev_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(opq.size() == 0 && !req_valid && req_ready) && n < 2000);
    vectors++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout: not idle after %0d cycles, required idle", name, n);
      opq.delete();
    end
  endtask

  task automatic test_reset();
    int c0;
    rst = 1; req_valid3 = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_rst, mem_clk, mem_we, mem_oe, mem_nib, req_ready, rsp_valid, rsp_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_outputs: got rst%b clk%b we%b oe%b nib%h rdy%b vld%b dat%h", mem_rst, mem_clk, mem_we, mem_oe, mem_nib, req_ready, rsp_valid, rsp_data);
    end
    vectors++;
    if ({mem_rst3, mem_clk3, req_ready3, rsp_valid3} !== 4'b1000) begin
      errors++; $display("FAIL reset_outputs3: got %b required 1000", {mem_rst3, mem_clk3, req_ready3, rsp_valid3});
    end
    clr();
    rst = 0; c0 = cyc;
    @(negedge clk);
    vectors++;
    if ({mem_clk, mem_rst, req_ready} !== 3'b110) begin
      errors++; $display("FAIL init_beat_high: clk/rst/rdy %b required 110", {mem_clk, mem_rst, req_ready});
    end
    @(negedge clk);
    vectors++;
    if ({mem_clk, mem_rst, req_ready} !== 3'b001 || cyc != c0 + 2) begin
      errors++; $display("FAIL ready_at_2: clk/rst/rdy %b cycle %0d required 001 at %0d", {mem_clk, mem_rst, req_ready}, cyc - c0, 2);
    end
    vectors++;
    if (ev_q.size() != 1 || ev_q[0] !== ev(1'b1, 1'b0, 1'b0, 4'h0)) begin
      errors++; $display("FAIL init_pulses: %0d rising edges required 1 with mem_rst", ev_q.size());
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready3 !== 1'b0) begin
      errors++; $display("FAIL ready3_early: got %b at cycle 5 required 0", req_ready3);
    end
    @(negedge clk);
    vectors++;
    if (req_ready3 !== 1'b1) begin
      errors++; $display("FAIL ready3_at_6: got %b required 1", req_ready3);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] nibs [3];
    logic [7:0] exp;
    int t;
    clr();
    opq.push_back('{we: 1'b1, a: 3'd5, d: 8'hA7});
    ref_mem[5] = 8'hA7;
    wait_idle("write");
    nibs[0] = 4'h7; nibs[1] = 4'hA; nibs[2] = 4'h5;
    vectors++;
    if (acc_q.size() != 1 || rdy_q.size() != 1) begin
      errors++; $display("FAIL write_handshake: %0d accepts %0d ready rises, required 1 and 1", acc_q.size(), rdy_q.size());
      return;
    end
    t = acc_q[0];
    vectors++;
    if (rdy_q[0] - t != 7) begin
      errors++; $display("FAIL write_latency: ready after %0d cycles required 7", rdy_q[0] - t);
    end
    for (int k = 1; k <= 6; k++) begin
      exp = {(k % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, nibs[(k - 1) / 2]};
      vectors++;
      if (trace[t + k] !== exp) begin
        errors++; $display("FAIL write_beat_c%0d: pins %h required %h", k, trace[t + k], exp);
      end
    end
    vectors++;
    if (ev_q.size() != 3) begin
      errors++; $display("FAIL write_edges: %0d rising edges required 3", ev_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (ev_q[i] !== ev(1'b0, 1'b1, 1'b0, nibs[i])) begin
          errors++; $display("FAIL write_sample_%0d: got %h required %h", i, ev_q[i], ev(1'b0, 1'b1, 1'b0, nibs[i]));
        end
      end
    end
    vectors++;
    if (smem[5] !== 8'hA7) begin
      errors++; $display("FAIL write_mem5: sram holds %h required a7", smem[5]);
    end
  endtask

  task automatic test_readback();
    int t;
    clr();
    opq.push_back('{we: 1'b0, a: 3'd5, d: 8'h00});
    wait_idle("read");
    vectors++;
    if (acc_q.size() != 1 || rsp_cyc.size() != 1 || rdy_q.size() != 1) begin
      errors++; $display("FAIL read_handshake: %0d accepts %0d rsps %0d ready rises, required 1 each", acc_q.size(), rsp_cyc.size(), rdy_q.size());
      return;
    end
    t = acc_q[0];
    vectors++;
    if (rsp_cyc[0] - t != 4 || rdy_q[0] - t != 4) begin
      errors++; $display("FAIL read_latency: rsp %0d ready %0d cycles required 4 and 4", rsp_cyc[0] - t, rdy_q[0] - t);
    end
    vectors++;
    if (rsp_dat[0] !== ref_mem[5]) begin
      errors++; $display("FAIL read_data: got %h required %h", rsp_dat[0], ref_mem[5]);
    end
    vectors++;
    if (trace[t + 1] !== 8'h15 || trace[t + 2] !== 8'h95 || trace[t + 3] !== 8'h15) begin
      errors++; $display("FAIL read_pins: %h %h %h required 15 95 15", trace[t + 1], trace[t + 2], trace[t + 3]);
    end
    vectors++;
    if (ev_q.size() != 1 || ev_q[0] !== ev(1'b0, 1'b0, 1'b1, 4'h5)) begin
      errors++; $display("FAIL read_edges: %0d rising edges required 1 with oe and nib 5", ev_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clr();
    opq.push_back('{we: 1'b1, a: 3'd0, d: 8'h3C});
    opq.push_back('{we: 1'b1, a: 3'd7, d: 8'hFF});
    opq.push_back('{we: 1'b0, a: 3'd0, d: 8'h00});
    opq.push_back('{we: 1'b0, a: 3'd7, d: 8'h00});
    ref_mem[0] = 8'h3C; ref_mem[7] = 8'hFF;
    wait_idle("b2b");
    vectors++;
    if (acc_q.size() != 4 || rsp_dat.size() != 2) begin
      errors++; $display("FAIL b2b_counts: %0d accepts %0d rsps required 4 and 2", acc_q.size(), rsp_dat.size());
      return;
    end
    vectors++;
    if (acc_q[1] - acc_q[0] != 7 || acc_q[2] - acc_q[1] != 7 || acc_q[3] - acc_q[2] != 4) begin
      errors++; $display("FAIL b2b_spacing: %0d %0d %0d required 7 7 4", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1], acc_q[3] - acc_q[2]);
    end
    vectors++;
    if (rsp_dat[0] !== 8'h3C || rsp_dat[1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_data: got %h %h required 3c ff", rsp_dat[0], rsp_dat[1]);
    end
    vectors++;
    if (ev_q.size() != 8) begin
      errors++; $display("FAIL b2b_edges: %0d rising edges required 8", ev_q.size());
    end
  endtask

  task automatic test_mid_write_reset();
    int n;
    clr();
    opq.push_back('{we: 1'b1, a: 3'd2, d: 8'h55});
    n = 0;
    while (acc_q.size() == 0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (acc_q.size() == 0) begin
      errors++; $display("FAIL mwr_accept: no accept in %0d cycles required one", n);
      opq.delete();
      return;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_we, mem_oe, mem_nib} !== {1'b1, 1'b0, 4'h5}) begin
      errors++; $display("FAIL mwr_in_wr1: we/oe/nib %b required 1_0_0101", {mem_we, mem_oe, mem_nib});
    end
    rst = 1;
    @(negedge clk);
    vectors++;
    if ({mem_rst, mem_we, rsp_valid, req_ready, rsp_data} !== {4'b1000, 8'h00}) begin
      errors++; $display("FAIL mwr_reset: rst/we/vld/rdy %b data %h required 1000 00", {mem_rst, mem_we, rsp_valid, req_ready}, rsp_data);
    end
    ev_q.delete();
    rst = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || ev_q.size() != 1 || ev_q[0] !== ev(1'b1, 1'b0, 1'b0, 4'h0)) begin
      errors++; $display("FAIL mwr_init: ready %b with %0d edges required 1 with one reset edge", req_ready, ev_q.size());
    end
    clr();
    opq.push_back('{we: 1'b0, a: 3'd2, d: 8'h00});
    opq.push_back('{we: 1'b1, a: 3'd2, d: 8'h12});
    opq.push_back('{we: 1'b0, a: 3'd2, d: 8'h00});
    wait_idle("mwr");
    vectors++;
    if (rsp_dat.size() != 2 || rsp_dat[0] !== ref_mem[2] || rsp_dat[1] !== 8'h12) begin
      errors++; $display("FAIL mwr_readback: %0d rsps first %h second %h required %h then 12", rsp_dat.size(), rsp_dat.size() > 0 ? rsp_dat[0] : 8'h0, rsp_dat.size() > 1 ? rsp_dat[1] : 8'h0, ref_mem[2]);
    end
    ref_mem[2] = 8'h12;
  endtask

  task automatic test_random();
    op_t ops [$];
    op_t o;
    int nedges, ri;
    clr();
    nedges = 0;
    for (int i = 0; i < 40; i++) begin
      o.we = 1'($urandom);
      o.a  = 3'($urandom_range(0, 7));
      o.d  = 8'($urandom);
      ops.push_back(o);
      opq.push_back(o);
      nedges += o.we ? 3 : 1;
    end
    wait_idle("random");
    vectors++;
    if (acc_q.size() != ops.size()) begin
      errors++; $display("FAIL rand_accepts: %0d required %0d", acc_q.size(), ops.size());
      return;
    end
    vectors++;
    if (ev_q.size() != nedges) begin
      errors++; $display("FAIL rand_edges: %0d rising edges required %0d", ev_q.size(), nedges);
    end
    ri = 0;
    for (int i = 0; i < ops.size(); i++) begin
      if (i + 1 < ops.size()) begin
        vectors++;
        if (acc_q[i + 1] - acc_q[i] != (ops[i].we ? 7 : 4)) begin
          errors++; $display("FAIL rand_spacing_%0d: %0d cycles required %0d", i, acc_q[i + 1] - acc_q[i], ops[i].we ? 7 : 4);
        end
      end
      if (ops[i].we) ref_mem[ops[i].a] = ops[i].d;
      else begin
        vectors++;
        if (ri >= rsp_dat.size()) begin
          errors++; $display("FAIL rand_missing_rsp_%0d: no response required %h", i, ref_mem[ops[i].a]);
        end else if (rsp_dat[ri] !== ref_mem[ops[i].a] || rsp_cyc[ri] - acc_q[i] != 4) begin
          errors++; $display("FAIL rand_read_%0d: data %h after %0d cycles required %h after 4", i, rsp_dat[ri], rsp_cyc[ri] - acc_q[i], ref_mem[ops[i].a]);
        end
        ri++;
      end
    end
    vectors++;
    if (rsp_dat.size() != ri) begin
      errors++; $display("FAIL rand_rsp_count: %0d required %0d", rsp_dat.size(), ri);
    end
  endtask

  task automatic test_half3();
    int n, bad;
    logic expclk;
    for (int op = 0; op < 2; op++) begin
      n = 0;
      while (!req_ready3 && n < 100) begin @(negedge clk); n++; end
      req_we = (op == 0); req_addr = 3'd5; req_wdata = 8'hA7;
      req_valid3 = 1;
      @(negedge clk);
      req_valid3 = 0; req_addr = 3'd1; req_wdata = 8'h00;
      n = 1; bad = 0;
      while (!req_ready3 && n < 60) begin
        expclk = ((n - 1) % 6) >= 3 && n <= 6 * ((op == 0) ? 3 : 1);
        if (mem_clk3 !== expclk || (op == 0 && mem_we3 !== 1'b1) || (op == 1 && mem_oe3 !== 1'b1)) bad++;
        @(negedge clk); n++;
      end
      vectors++;
      if (n != ((op == 0) ? 19 : 8)) begin
        errors++; $display("FAIL half3_latency_%s: %0d cycles required %0d", op == 0 ? "wr" : "rd", n, (op == 0) ? 19 : 8);
      end
      vectors++;
      if (bad != 0) begin
        errors++; $display("FAIL half3_pins_%s: %0d bad cycles required 0", op == 0 ? "wr" : "rd", bad);
      end
    end
    vectors++;
    if (rsp_valid3 !== 1'b1 || rsp_data3 !== 8'hA7) begin
      errors++; $display("FAIL half3_read: valid %b data %h required 1 a7", rsp_valid3, rsp_data3);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i * 29 + 19);
    rst = 1; req_valid3 = 0;
    test_reset();
    test_single_write();
    test_readback();
    test_back_to_back();
    test_mid_write_reset();
    test_random();
    test_half3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/jar_sram_host.md
# jar_sram_host

Host-side controller for the nibble-serial 8×8 SRAM macro. It accepts parallel read/write requests on a valid/ready interface and sequences them onto the SRAM's 8-bit pin bus. On that bus the host supplies the SRAM clock, reset, OE/WE and a shared 4-bit address/data nibble, and samples the SRAM's 8-bit read data. It sits between on-chip logic (or a test harness) and the SRAM pins, and is the initiator end of that protocol.

## Interface
- `AW`, 3, SRAM address width (DEPTH = 2**AW = 8).
- `DW`, 8, data width; nibble width is DW/2 = 4.
- `HALF`, 1, host cycles per SRAM clock half-period (≥1).

Ports:
- `clk`  in  1  host clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  host idle, request accepted when valid&&ready.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  target address.
- `req_wdata`  in  DW  write data.
- `rsp_valid`  out  1  one-cycle pulse, read data valid.
- `rsp_data`  out  DW  read data, held until next read completes.
- `mem_clk`  out  1  SRAM clock (pin io_in[0]).
- `mem_rst`  out  1  SRAM reset (io_in[1]).
- `mem_we`  out  1  SRAM write enable (io_in[2]).
- `mem_oe`  out  1  SRAM output enable (io_in[3]).
- `mem_nib`  out  4  shared address/data nibble (io_in[7:4]).
- `mem_dout`  in  DW  SRAM read data (io_out).

## Operation
- **Beat:** one SRAM clock period of 2·HALF cycles. The first HALF cycles have mem_clk=0 and the last HALF have mem_clk=1. mem_rst/we/oe/nib are set at beat start and held for the whole beat. The SRAM samples on the mem_clk rising edge.
- **States:** INIT, IDLE, WR0, WR1, WR2, RD, RDS.
- **INIT:** entered on reset. One beat with mem_rst=1, we=oe=0, nib=0. This clears the SRAM nibble counter. Goes to IDLE.
- **IDLE:** req_ready=1, mem_clk=0, all mem_* = 0.
  - Accepted write: latch addr/wdata, go to WR0.
  - Accepted read: latch addr, go to RD.
- **WR0/WR1/WR2:** one beat each with we=1, oe=0.
  - WR0: nib = wdata[3:0].
  - WR1: nib = wdata[7:4].
  - WR2: nib = {0, addr}.
  - After WR2, go to IDLE.
- **RD:** one beat with oe=1, we=0, nib={0,addr}; go to RDS.
- **RDS:** one cycle with mem_clk=0, oe=1, nib held. Capture mem_dout into rsp_data at the end of the cycle. Go to IDLE and pulse rsp_valid.
- **Reset:** applies in any state, including mid-write or mid-read.
  - FSM goes to INIT; no rsp_valid is issued.
  - The partial SRAM write is abandoned because INIT resets the SRAM counter.
  - rsp_data is cleared to 0.
- **Ignored requests:** req_valid outside IDLE is ignored; the requester must hold it. Inputs are sampled only on acceptance.
- **Addressing:** upper nib bit is always 0 for AW=3. There is no wrap or range check; the address is truncated to AW bits.

## Timing
- **Reset values:** while rst=1: mem_rst=1, mem_clk=0, mem_we=mem_oe=0, mem_nib=0, req_ready=0, rsp_valid=0, rsp_data=0.
- **After reset (HALF=1):** rst is low at cycle 0.
  - INIT beat occupies cycles 0–1, with mem_clk high in cycle 1.
  - IDLE and req_ready=1 from cycle 2.
- **Write** accepted at cycle T: beats at T+1..T+6; req_ready again at T+7. Latency is 6·HALF+1.
- **Read** accepted at cycle T: RD beat at T+1..T+2, RDS at T+3, rsp_valid and rsp_data at T+4, req_ready at T+4. Latency is 2·HALF+2.
- **Glitch-free outputs:** all mem_* outputs are registered. mem_clk toggles only at half-period boundaries. Control/nib changes coincide only with mem_clk falling or staying low.
- **Back-to-back requests:** a request held valid is accepted on the first req_ready cycle. Maximum throughput is one write per 6·HALF+1 cycles.

## Structure
- **Package `jar_sram_pkg`:** state enum (INIT, IDLE, WR0, WR1, WR2, RD, RDS) and the pin-index constants (CLK=0, RST=1, WE=2, OE=3, NIB_LO=4). The SRAM top reuses these constants.
- **Sub-module `jar_sram_clkgen`:**
  - Phase counter (0..2·HALF-1) producing mem_clk and a beat_end strobe on the last cycle of each beat.
  - Cleared by rst.
  - Enabled only while the FSM is in a beat state.
- **Top (`jar_sram_host`):** FSM, request latches, and the output registers.

## Test plan
- **Reset:** hold rst 3 cycles → all outputs at reset values. After release, exactly one mem_clk pulse with mem_rst=1, then req_ready=1 at cycle 2.
- **Single write:** write addr=5, data=0xA7 → beats carry nib 0x7, 0xA, 0x5 with we=1, oe=0; req_ready returns at T+7. SRAM model mem[5]=0xA7.
- **Readback:** read addr=5 after the write → rsp_valid at T+4, rsp_data=0xA7, oe=1 through RDS.
- **Back-to-back:** write addr=0 data=0x3C, then write addr=7 data=0xFF, then read 0 and read 7 with req_valid held continuously → rsp 0x3C then 0xFF; no extra mem_clk edges between requests.
- **Mid-write reset:** assert rst during WR1 of write addr=2, data=0x55 → INIT beat issued, mem[2] unchanged. A subsequent write addr=2, data=0x12 then read → 0x12.
- **HALF=3 (parameter):** same write/read → mem_clk high/low 3 cycles each, write latency 19 cycles, read latency 8 cycles, data correct.
